// File: rtl/ram_mux_sequencer.sv
// ram_mux_sequencer: accepts one word, drives it to an external bit
// multiplexer and walks the select index to serialize 1..DATA_W bits
// over a valid/ready stream. One idle bubble separates words.
// Build option: define RAM_MUX_MSB_FIRST_EN to emit the most-significant
// bits first (select counts down from DATA_W-1); otherwise the
// least-significant bits are emitted first (select counts up from 0).
module ram_mux_sequencer #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W:0]    in_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic [DATA_W-1:0] mux_data,
  output logic [SEL_W-1:0]  mux_sel,
  output logic              mux_valid,
  input  logic              mux_bit,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [SEL_W:0] FULL_LEN = (SEL_W+1)'(DATA_W);
`ifdef RAM_MUX_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] START_SEL = SEL_W'(DATA_W-1);
`else
  localparam logic [SEL_W-1:0] START_SEL = '0;
`endif

  state_t             state, state_nxt;
  logic [SEL_W:0]     cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic               last_bit;

  // Zero or oversize lengths both mean a full word.
  function automatic logic [SEL_W:0] sat_len(input logic [SEL_W:0] len);
    if (len == '0 || len > FULL_LEN) return FULL_LEN;
    return len;
  endfunction

  // Next select index in the configured scan direction.
  function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] sel);
`ifdef RAM_MUX_MSB_FIRST_EN
    return sel - SEL_W'(1);
`else
    return sel + SEL_W'(1);
`endif
  endfunction

  // The multiplexer output is passed straight through with no register.
  assign out_bit  = mux_bit;
  assign last_bit = (cnt == (SEL_W+1)'(1));

  // State, captured word, select index and remaining-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mux_data <= '0;
      mux_sel  <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      mux_data <= data_nxt;
      mux_sel  <= sel_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Next-state logic and Moore-style stream outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = mux_sel;
    data_nxt  = mux_data;
    in_ready  = 1'b0;
    mux_valid = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_nxt  = in_data;
          cnt_nxt   = sat_len(in_len);
          sel_nxt   = START_SEL;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        mux_valid = 1'b1;
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = last_bit;
        // Abort wins over a same-cycle handshake: the current bit is dropped.
        if (abort) begin
          state_nxt = IDLE;
        end else if (out_ready) begin
          if (last_bit) begin
            // Select stays on the final index so it never wraps.
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - (SEL_W+1)'(1);
            sel_nxt = step_sel(mux_sel);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_mux_sequencer.sv
// Bench for ram_mux_sequencer with a behavioural 16:1 bit multiplexer.
// Stimulus pushes expected {bit, select, last} entries into a queue; a
// monitor pops one per output handshake and compares.
module tb_ram_mux_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic [4:0]  in_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic [15:0] mux_data;
  logic [3:0]  mux_sel;
  logic        mux_valid;
  logic        mux_bit;
  logic        out_bit;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        busy;

  typedef struct {
    logic       b;
    logic [3:0] sel;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  ram_mux_sequencer #(.DATA_W(16), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
    .mux_data(mux_data), .mux_sel(mux_sel), .mux_valid(mux_valid),
    .mux_bit(mux_bit), .out_bit(out_bit), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  // Behavioural 16:1 multiplexer
  assign mux_bit = mux_valid ? mux_data[mux_sel] : 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic b, input int sel, input logic last);
    exp_t e;
    e.b = b; e.sel = 4'(sel); e.last = last;
    q.push_back(e);
  endtask

  // First n bits of word 16'h8E8E in the configured order (hand-derived).
  task automatic push_8e(input int n);
    logic pat [8];
`ifdef RAM_MUX_MSB_FIRST_EN
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < n; i++) push(pat[i % 8], 15 - i, i == 15);
`else
    pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < n; i++) push(pat[i % 8], i, i == 15);
`endif
  endtask

  // n constant bits of a full word in the configured order.
  task automatic push_const(input logic b, input int n, input int len);
    for (int i = 0; i < n; i++) begin
`ifdef RAM_MUX_MSB_FIRST_EN
      push(b, 15 - i, i == len - 1);
`else
      push(b, i, i == len - 1);
`endif
    end
  endtask

  // Offer a word and return just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [4:0] l, input bit hold);
    int n;
    bit ok;
    in_data = d; in_len = l; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Count edges until in_ready returns; optionally toggle out_ready each cycle.
  task automatic wait_idle(input bit toggle, output int n);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (toggle) out_ready = ~out_ready;
    end
    if (!in_ready) check("idle_timeout", 0, 1);
    out_ready = 1'b1;
  endtask

  // Poll until the select reaches s while a word is in flight.
  task automatic wait_sel(input logic [3:0] s);
    int n;
    n = 0;
    while (!(out_valid && mux_sel == s) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("sel_timeout", 0, 1);
  endtask

  // Scoreboard monitor: one pop per accepted bit, select held while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !abort) begin
      check("mux_valid", mux_valid, 1);
      if (out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_bit", out_bit, e.b);
          check("mux_sel", mux_sel, e.sel);
          check("out_last", out_last, e.last);
        end
      end else if (q.size() != 0) begin
        check("sel_hold", mux_sel, q[0].sel);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_mux_valid", mux_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_mux_sel", mux_sel, 0);
    check("rst_mux_data", mux_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full word, length 0 means 16; accept is cycle 0, ready returns in cycle 17.
    push_8e(16);
    send(16'h8E8E, 5'd0, 1'b0);
    wait_idle(1'b0, n);
    check("full_latency", n, 16);
    check("queue_drained_full", q.size(), 0);
    check("data_held", mux_data, 16'h8E8E);
    check("idle_out_valid", out_valid, 0);

    // Oversize length saturates to a full word.
    push_8e(16);
    send(16'h8E8E, 5'd31, 1'b0);
    wait_idle(1'b0, n);
    check("sat_latency", n, 16);
    check("queue_drained_sat", q.size(), 0);

    // Five bits of 16'h001F with out_ready toggling.
`ifdef RAM_MUX_MSB_FIRST_EN
    for (int i = 0; i < 5; i++) push(1'b0, 15 - i, i == 4);
`else
    for (int i = 0; i < 5; i++) push(1'b1, i, i == 4);
`endif
    send(16'h001F, 5'd5, 1'b0);
    wait_idle(1'b1, n);
    check("queue_drained_len5", q.size(), 0);

    // Abort when select reaches 6.
`ifdef RAM_MUX_MSB_FIRST_EN
    push_8e(9);
`else
    push_8e(6);
`endif
    send(16'h8E8E, 5'd0, 1'b0);
    wait_sel(4'd6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("queue_drained_abort", q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", out_valid, 0);
    end

    // Abort while idle does nothing.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_ready", in_ready, 1);

    // Reset pulse when select reaches 9.
`ifdef RAM_MUX_MSB_FIRST_EN
    push_8e(6);
`else
    push_8e(9);
`endif
    send(16'h8E8E, 5'd0, 1'b0);
    wait_sel(4'd9);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mux_valid", mux_valid, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_mux_sel", mux_sel, 0);
    check("midrst_mux_data", mux_data, 0);
    check("queue_drained_rst", q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("postrst_quiet", out_valid, 0);
    end

    // Back-to-back words with in_valid held: 16 ones, one bubble, 16 zeros.
    push_const(1'b1, 16, 16);
    push_const(1'b0, 16, 16);
    send(16'hFFFF, 5'd0, 1'b1);
    in_data = 16'h0000;
    wait_idle(1'b0, n);
    check("b2b_first_latency", n, 16);
    check("bubble_out_valid", out_valid, 0);
    check("bubble_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_second_busy", busy, 1);
    wait_idle(1'b0, n);
    check("b2b_second_latency", n, 16);
    check("queue_drained_b2b", q.size(), 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_mux_sequencer.md
RAM_MUX_SEQUENCER -- requirements
Module: ram_mux_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, word width fed to the bit multiplexer; SEL_W, default 4, select width (clog2 DATA_W).
REQ-002 Ports SHALL be (name direction width meaning):
- clk input 1 clock, all state on rising edge
- rst_n input 1 asynchronous active-low reset
- in_data input DATA_W word to serialize
- in_len input SEL_W+1 number of bits to emit (1..DATA_W; 0 means DATA_W)
- in_valid input 1 word offered
- in_ready output 1 sequencer accepts word
- abort input 1 synchronous cancel of current word
- mux_data output DATA_W captured word driven to bit multiplexer
- mux_sel output SEL_W bit index driven to multiplexer
- mux_valid output 1 multiplexer enable
- mux_bit input 1 selected bit returned by multiplexer (combinational path)
- out_bit output 1 serialized bit
- out_valid output 1 out_bit valid
- out_last output 1 final bit of word
- out_ready input 1 consumer accepts bit
- busy output 1 word in progress

Function
REQ-003 FSM SHALL have states IDLE and SHIFT only.
REQ-004 In IDLE, in_ready SHALL be 1, mux_valid and out_valid 0.
REQ-005 On in_valid && in_ready, the block SHALL capture in_data into mux_data, load the bit counter with the effective length, set mux_sel to the start index, and enter SHIFT the next cycle.
REQ-006 In SHIFT, in_ready SHALL be 0; mux_valid, out_valid and busy SHALL be 1.
REQ-007 out_bit SHALL equal mux_bit combinationally (zero added latency).
REQ-008 mux_sel SHALL advance by one index only on out_valid && out_ready; it SHALL hold while out_ready is 0.
REQ-009 out_last SHALL be 1 while the remaining-bit count equals 1.
REQ-010 On handshake with out_last=1, the FSM SHALL return to IDLE; a new word SHALL be accepted no earlier than the following cycle (one bubble per word).
REQ-011 mux_sel SHALL never wrap: maximum index DATA_W-1 (ascending) or minimum 0 (descending) is reached only on the last bit of a full-length word.
REQ-012 in_len greater than DATA_W SHALL be saturated to DATA_W.
REQ-013 abort=1 in SHIFT SHALL force IDLE next cycle without emitting further bits; abort has priority over the out handshake; abort in IDLE SHALL be ignored.
REQ-014 mux_data SHALL hold its value between words (no clearing on completion).

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE, mux_data 0, mux_sel 0, bit counter 0, in_ready 1 (after release), mux_valid/out_valid/out_last/busy 0.
REQ-016 Reset mid-word SHALL discard the word; no out_valid SHALL appear after release until a new word is accepted.

Configuration
REQ-017 Macro RAM_MUX_MSB_FIRST_EN: defined -> start index DATA_W-1, mux_sel decrements, emitting the in_len most-significant bits; undefined -> start index 0, mux_sel increments, emitting the in_len least-significant bits.

Verification
REQ-018 The bench SHALL instance ram_mux_sequencer with a behavioural 16:1 multiplexer and cover:
- LSB-first, in_data=16'h8E8E, in_len=0, out_ready=1 -> 16 bits 0,1,1,1,0,0,0,1 x2, mux_sel 0..15, out_last on bit 16, in_ready high 17 cycles after accept.
- MSB-first build, same word -> bits 1,0,0,0,1,1,1,0 x2, mux_sel 15..0.
- in_len=5, in_data=16'h001F, out_ready toggling 1/0 -> exactly five 1-bits, mux_sel stable on every out_ready=0 cycle.
- abort asserted with mux_sel=6 -> IDLE next cycle, out_valid 0, in_ready 1, no further bits.
- rst_n pulsed low during mux_sel=9 -> all outputs at reset values immediately, no out_valid until next accept.
- Back-to-back words 16'hFFFF then 16'h0000 with in_valid held -> 16 ones, one bubble cycle, 16 zeros.
